delay_commutator_p: RTL and testbench

DELAY_COMMUTATOR_P -- requirements
Module: delay_commutator_p

---
 rtl/delay_commutator_p.sv | 113 +++++++++++
 tb/tb_delay_commutator_p.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_commutator_p.sv
// Delay commutator between FFT butterfly stages: pre-delay on the lower path,
// a swap switch driven by the sample counter, and a post-delay on the upper path.
module delay_commutator_p #(
    parameter int DATA_WIDTH = 16,
    parameter int DELAY      = 16,
    parameter int CNT_W      = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  in_valid,
    input  logic                  in_sync,
    input  logic [DATA_WIDTH-1:0] in0_re,
    input  logic [DATA_WIDTH-1:0] in0_im,
    input  logic [DATA_WIDTH-1:0] in1_re,
    input  logic [DATA_WIDTH-1:0] in1_im,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out0_re,
    output logic [DATA_WIDTH-1:0] out0_im,
    output logic [DATA_WIDTH-1:0] out1_re,
    output logic [DATA_WIDTH-1:0] out1_im
);

    // Real and imaginary parts travel together as one packed word.
    localparam int PW = 2 * DATA_WIDTH;

    logic          out_valid_reg;
    logic [PW-1:0] out0_reg;
    logic [PW-1:0] out1_reg;

    assign out_valid          = out_valid_reg;
    assign {out0_re, out0_im} = out0_reg;
    assign {out1_re, out1_im} = out1_reg;

    generate
        if (DELAY == 0) begin : g_bypass
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    out_valid_reg <= 1'b0;
                    out0_reg      <= '0;
                    out1_reg      <= '0;
                end else begin
                    out_valid_reg <= in_valid;
                    if (in_valid) begin
                        out0_reg <= {in0_re, in0_im};
                        out1_reg <= {in1_re, in1_im};
                    end
                end
            end
        end else begin : g_delay
            localparam int LOG2D  = $clog2(DELAY);
            localparam int FILL_W = CNT_W + 1;
            localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(2 * DELAY - 1);
            localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(2 * DELAY);

            logic [CNT_W-1:0]  cnt_reg;
            logic [CNT_W-1:0]  cnt_next;
            logic [CNT_W-1:0]  n_cur;
            logic [FILL_W-1:0] fill_reg;
            logic [FILL_W-1:0] fill_next;
            logic [FILL_W-1:0] fill_cur;
            logic              sw;
            logic [PW-1:0]     a_cur;
            logic [PW-1:0]     b_cur;
            logic [PW-1:0]     p_cur;
            logic [PW-1:0]     q_cur;
            logic [PW-1:0]     b_line [DELAY];
            logic [PW-1:0]     p_line [DELAY];

            // A synced sample is treated as n=0 of a fresh stream; old
            // delay-line contents stay but the fill count forces them invalid.
            always_comb begin
                n_cur     = in_sync ? '0 : cnt_reg;
                fill_cur  = in_sync ? '0 : fill_reg;
                sw        = n_cur[LOG2D];
                a_cur     = {in0_re, in0_im};
                b_cur     = b_line[DELAY-1];
                p_cur     = sw ? b_cur : a_cur;
                q_cur     = sw ? a_cur : b_cur;
                cnt_next  = (n_cur == CNT_LAST) ? '0 : n_cur + CNT_W'(1);
                fill_next = (fill_cur == FILL_FULL) ? fill_cur : fill_cur + FILL_W'(1);
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    cnt_reg       <= '0;
                    fill_reg      <= '0;
                    out_valid_reg <= 1'b0;
                    out0_reg      <= '0;
                    out1_reg      <= '0;
                    for (int i = 0; i < DELAY; i++) begin
                        b_line[i] <= '0;
                        p_line[i] <= '0;
                    end
                end else begin
                    out_valid_reg <= in_valid && (fill_cur == FILL_FULL);
                    if (in_valid) begin
                        cnt_reg   <= cnt_next;
                        fill_reg  <= fill_next;
                        out0_reg  <= p_line[DELAY-1];
                        out1_reg  <= q_cur;
                        b_line[0] <= {in1_re, in1_im};
                        p_line[0] <= p_cur;
                        for (int i = 1; i < DELAY; i++) begin
                            b_line[i] <= b_line[i-1];
                            p_line[i] <= p_line[i-1];
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_delay_commutator_p.sv
// Bench for delay_commutator_p: DELAY=4 instance checked against a sample-index
// reference model through a scoreboard queue, plus a DELAY=0 instance alongside.
module tb_delay_commutator_p;

    localparam int DW = 16;
    localparam int D  = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          in_valid, in_sync;
    logic [DW-1:0] in0_re, in0_im, in1_re, in1_im;
    logic          out_valid;
    logic [DW-1:0] out0_re, out0_im, out1_re, out1_im;
    logic          z_valid;
    logic [DW-1:0] z0_re, z0_im, z1_re, z1_im;

    always #5 CLK = ~CLK;

    delay_commutator_p #(.DATA_WIDTH(DW), .DELAY(D), .CNT_W(3)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_sync(in_sync),
        .in0_re(in0_re), .in0_im(in0_im), .in1_re(in1_re), .in1_im(in1_im),
        .out_valid(out_valid), .out0_re(out0_re), .out0_im(out0_im),
        .out1_re(out1_re), .out1_im(out1_im)
    );

    delay_commutator_p #(.DATA_WIDTH(DW), .DELAY(0), .CNT_W(1)) dut0 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_sync(in_sync),
        .in0_re(in0_re), .in0_im(in0_im), .in1_re(in1_re), .in1_im(in1_im),
        .out_valid(z_valid), .out0_re(z0_re), .out0_im(z0_im),
        .out1_re(z1_re), .out1_im(z1_im)
    );

    typedef struct {
        logic        v;
        logic [31:0] o0, o1;
        logic        zv;
        logic [31:0] z0, z1;
    } exp_t;

    typedef struct {
        logic [15:0] i0, i1;
        logic        ev;
        logic [15:0] e0, e1;
    } vec_t;

    exp_t        sb[$];
    vec_t        tab[16];
    int          checks = 0;
    int          passes = 0;
    int          mn = 0;
    logic [31:0] h0[0:2047];
    logic [31:0] h1[0:2047];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    endtask

    // Reference model written directly from the sample-index equations.
    function automatic logic sw_of(int m);
        return ((m / D) % 2) == 1;
    endfunction
    function automatic logic [31:0] a_of(int m);
        return h0[m];
    endfunction
    function automatic logic [31:0] b_of(int m);
        return h1[m - D];
    endfunction
    function automatic logic [31:0] p_of(int m);
        return sw_of(m) ? b_of(m) : a_of(m);
    endfunction
    function automatic logic [31:0] q_of(int m);
        return sw_of(m) ? a_of(m) : b_of(m);
    endfunction

    task automatic model_accept(input logic sy, input logic [31:0] x0, input logic [31:0] x1,
                                inout exp_t e);
        if (sy) mn = 0;
        h0[mn] = x0;
        h1[mn] = x1;
        e.v  = (mn >= 2 * D);
        e.o0 = e.v ? p_of(mn - D) : 32'h0;
        e.o1 = e.v ? q_of(mn) : 32'h0;
        mn++;
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            $display("FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        e = sb.pop_front();
        chk("out_valid", {31'b0, out_valid}, {31'b0, e.v});
        if (e.v) begin
            chk("out0", {out0_re, out0_im}, e.o0);
            chk("out1", {out1_re, out1_im}, e.o1);
        end
        chk("d0_valid", {31'b0, z_valid}, {31'b0, e.zv});
        if (e.zv) begin
            chk("d0_out0", {z0_re, z0_im}, e.z0);
            chk("d0_out1", {z1_re, z1_im}, e.z1);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic v, input logic sy, input logic [31:0] x0, input logic [31:0] x1);
        exp_t e;
        e = '{default: '0};
        in_valid = v;
        in_sync  = sy;
        {in0_re, in0_im} = x0;
        {in1_re, in1_im} = x1;
        if (v) model_accept(sy, x0, x1, e);
        e.zv = v;
        e.z0 = x0;
        e.z1 = x1;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        check_out();
        @(negedge CLK);
    endtask

    function automatic logic [31:0] ramp(int r0, int r1, input bit upper);
        logic [15:0] re;
        re = upper ? 16'(r1) : 16'(r0);
        return {re, re + 16'd1000};
    endfunction

    task automatic do_reset();
        in_valid = 1'b0;
        in_sync  = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        mn = 0;
        sb.delete();
    endtask

    initial begin
        int first_v;
        int idle_cnt;
        RST = 1'b1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in0_re = '0; in0_im = '0; in1_re = '0; in1_im = '0;

        for (int n = 0; n < 16; n++) begin
            tab[n].i0 = 16'(n);
            tab[n].i1 = 16'(100 + n);
            tab[n].ev = (n >= 8);
            tab[n].e0 = (n < 12) ? 16'(100 + n - 8) : 16'(8 + n - 12);
            tab[n].e1 = (n < 12) ? 16'(104 + n - 8) : 16'(12 + n - 12);
        end

        repeat (2) @(negedge CLK);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out0", {out0_re, out0_im}, 32'h0);
        chk("rst_out1", {out1_re, out1_im}, 32'h0);
        chk("rst_d0_valid", {31'b0, z_valid}, 32'h0);
        RST = 1'b0;

        // Continuous ramp, then the same ramp with a bubble after each sample.
        for (int tg = 0; tg < 2; tg++) begin
            do_reset();
            for (int n = 0; n < 16; n++) begin
                cycle(1'b1, 1'b0, {tab[n].i0, tab[n].i0 + 16'd1000}, {tab[n].i1, tab[n].i1 + 16'd1000});
                chk("tab_valid", {31'b0, out_valid}, {31'b0, tab[n].ev});
                if (tab[n].ev) begin
                    chk("tab_out0", {out0_re, out0_im}, {tab[n].e0, tab[n].e0 + 16'd1000});
                    chk("tab_out1", {out1_re, out1_im}, {tab[n].e1, tab[n].e1 + 16'd1000});
                end
                $display("ramp tg=%0d n=%0d valid=%0b out0_re=%0d out1_re=%0d", tg, n, out_valid, out0_re, out1_re);
                if (tg == 1) begin
                    cycle(1'b0, 1'b0, 32'h0, 32'h0);
                    chk("bubble_valid", {31'b0, out_valid}, 32'h0);
                end
            end
        end

        // Sync pulse at ramp sample 13.
        do_reset();
        idle_cnt = 0;
        for (int k = 0; k < 26; k++) begin
            cycle(1'b1, k == 13, ramp(k, 100 + k, 1'b0), ramp(k, 100 + k, 1'b1));
            if (k >= 13 && k <= 20 && !out_valid) idle_cnt++;
            if (k == 21) begin
                chk("sync_out0", {16'h0, out0_re}, 32'd113);
                chk("sync_out1", {16'h0, out1_re}, 32'd117);
            end
        end
        chk("sync_idle_samples", idle_cnt, 8);
        $display("sync sequence idle_samples=%0d", idle_cnt);

        // Asynchronous reset pulse mid-stream at n=10.
        do_reset();
        for (int k = 0; k < 10; k++)
            cycle(1'b1, 1'b0, ramp(k, 100 + k, 1'b0), ramp(k, 100 + k, 1'b1));
        in_valid = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
        chk("async_rst_out0", {out0_re, out0_im}, 32'h0);
        chk("async_rst_out1", {out1_re, out1_im}, 32'h0);
        chk("async_rst_d0_out0", {z0_re, z0_im}, 32'h0);
        RST = 1'b0;
        @(negedge CLK);
        mn = 0;
        sb.delete();
        first_v = -1;
        for (int k = 0; k < 12; k++) begin
            cycle(1'b1, 1'b0, ramp(50 + k, 150 + k, 1'b0), ramp(50 + k, 150 + k, 1'b1));
            if (out_valid && first_v < 0) first_v = k;
        end
        chk("post_rst_first_valid", first_v, 8);
        $display("reset sequence first_valid_sample=%0d", first_v);

        // DELAY=0 instance, single register stage.
        cycle(1'b1, 1'b0, {16'd5, 16'd1005}, {16'd7, 16'd1007});
        chk("d0_five", {16'h0, z0_re}, 32'd5);
        chk("d0_seven", {16'h0, z1_re}, 32'd7);
        $display("delay0 out0_re=%0d out1_re=%0d valid=%0b", z0_re, z1_re, z_valid);

        // Random stream with random gaps and occasional sync.
        do_reset();
        for (int k = 0; k < 1000; k++) begin
            logic v, sy;
            v  = ($urandom_range(0, 3) != 0);
            sy = v && ($urandom_range(0, 299) == 0);
            cycle(v, sy, $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
